// File: rtl/fm_lfo.sv
// fm_lfo: global low-frequency oscillator shared by all FM operators.
// Produces the tremolo attenuation (am_val) and the vibrato position
// (vib_pos); both advance once per output sample on sample_tick and are held
// for the whole operator sweep.
// Optional feature macro: FM_LFO_TEST_EN (adds the lfo_test[1:0] port).
module fm_lfo #(
  parameter int TREM_STEPS    = 210,
  parameter int TREM_DIV_LOG2 = 6,
  parameter int VIB_DIV_LOG2  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       dam,
  input  logic       dvb,
`ifdef FM_LFO_TEST_EN
  input  logic [1:0] lfo_test,
`endif
  output logic [5:0] am_val,
  output logic [2:0] vib_pos,
  output logic       vib_deep,
  output logic       lfo_upd
);

  localparam int HALF_STEPS = TREM_STEPS / 2;

  logic [VIB_DIV_LOG2-1:0] timer_q, timer_d;
  logic [7:0]              trem_pos_q, trem_pos_d;
  logic [2:0]              vib_pos_q, vib_pos_d;
  logic                    load_q, load_d;
  logic [5:0]              am_val_q, am_val_d;
  logic                    vib_deep_q, vib_deep_d;
  logic                    lfo_upd_q, lfo_upd_d;

  logic                    test_clr;
  logic                    test_fast;
  logic                    trem_adv;
  logic                    vib_adv;
  logic [7:0]              tri_val;
  logic [5:0]              am_raw;

`ifdef FM_LFO_TEST_EN
  assign test_clr  = lfo_test[0];
  assign test_fast = lfo_test[1];
`else
  assign test_clr  = 1'b0;
  assign test_fast = 1'b0;
`endif

  // Step enables decoded from the pre-increment timer value.
  assign trem_adv = test_fast | (&timer_q[TREM_DIV_LOG2-1:0]);
  assign vib_adv  = test_fast | (&timer_q);

  // Next-state for the sample timer and the two LFO positions.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    timer_d    = timer_q;
    trem_pos_d = trem_pos_q;
    vib_pos_d  = vib_pos_q;
    load_d     = 1'b0;
    if (test_clr) begin
      timer_d    = '0;
      trem_pos_d = '0;
      vib_pos_d  = '0;
    end else if (sample_tick) begin
      timer_d = timer_q + VIB_DIV_LOG2'(1);
      load_d  = 1'b1;
      if (trem_adv) begin
        trem_pos_d = (trem_pos_q == 8'(TREM_STEPS - 1)) ? 8'd0 : trem_pos_q + 8'd1;
      end
      if (vib_adv) begin
        vib_pos_d = vib_pos_q + 3'd1;
      end
    end
  end

  // Tremolo triangle shaping from the current position and depth select.
  always_comb begin
    tri_val = (trem_pos_q < 8'(HALF_STEPS)) ? trem_pos_q
                                            : 8'(TREM_STEPS - int'(trem_pos_q));
    am_raw  = dam ? 6'(tri_val >> 2) : 6'(tri_val >> 4);
  end

  // Output stage: load one cycle after a tick, then pulse lfo_upd.
  always_comb begin
    am_val_d   = am_val_q;
    vib_deep_d = vib_deep_q;
    lfo_upd_d  = load_q & ~test_clr;
    if (test_clr) begin
      am_val_d = '0;
    end else if (load_q) begin
      am_val_d   = am_raw;
      vib_deep_d = dvb;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      trem_pos_q <= '0;
      vib_pos_q  <= '0;
      load_q     <= 1'b0;
      am_val_q   <= '0;
      vib_deep_q <= 1'b0;
      lfo_upd_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the order of these lines does not matter.
      timer_q    <= timer_d;
      trem_pos_q <= trem_pos_d;
      vib_pos_q  <= vib_pos_d;
      load_q     <= load_d;
      am_val_q   <= am_val_d;
      vib_deep_q <= vib_deep_d;
      lfo_upd_q  <= lfo_upd_d;
    end
  end

  assign am_val   = am_val_q;
  assign vib_pos  = vib_pos_q;
  assign vib_deep = vib_deep_q;
  assign lfo_upd  = lfo_upd_q;

endmodule

// File: tb/tb_fm_lfo.sv
// tb_fm_lfo: self-checking bench for fm_lfo. Each tick pushes the expected
// am_val/vib_deep onto a scoreboard; a monitor pops and compares whenever the
// DUT pulses lfo_upd. Directed checks cover reset, timing and boundaries.
module tb_fm_lfo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       dam;
  logic       dvb;
`ifdef FM_LFO_TEST_EN
  logic [1:0] lfo_test;
`endif
  logic [5:0] am_val;
  logic [2:0] vib_pos;
  logic       vib_deep;
  logic       lfo_upd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] am;
    logic       deep;
    int         pos;
  } exp_t;

  exp_t sb[$];

  int m_timer = 0;
  int m_trem  = 0;
  int m_vib   = 0;
  bit fast_mode = 1'b0;
  int am_at[0:209];
  int am_max = 0;

  fm_lfo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .dam         (dam),
    .dvb         (dvb),
`ifdef FM_LFO_TEST_EN
    .lfo_test    (lfo_test),
`endif
    .am_val      (am_val),
    .vib_pos     (vib_pos),
    .vib_deep    (vib_deep),
    .lfo_upd     (lfo_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference tremolo value for a position and depth.
  function automatic logic [5:0] am_of(input int pos, input logic d);
    int t;
    t = (pos < 105) ? pos : 210 - pos;
    return d ? 6'(t >> 2) : 6'(t >> 4);
  endfunction

  // Advance the reference model by one tick and queue the expected output.
  task automatic model_tick();
    bit ta;
    bit va;
    exp_t e;
    ta = fast_mode || ((m_timer % 64) == 63);
    va = fast_mode || (m_timer == 1023);
    m_timer = (m_timer + 1) % 1024;
    if (ta) m_trem = (m_trem + 1) % 210;
    if (va) m_vib = (m_vib + 1) % 8;
    e.am   = am_of(m_trem, dam);
    e.deep = dvb;
    e.pos  = m_trem;
    sb.push_back(e);
  endtask

  // One tick followed by one idle cycle; entered and left at posedge+1.
  task automatic tick();
    sample_tick = 1'b1;
    model_tick();
    @(posedge clk) #1;
    sample_tick = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_clear();
    m_timer = 0;
    m_trem  = 0;
    m_vib   = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
  endtask

  // Scoreboard monitor: compare on every lfo_upd pulse, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && lfo_upd === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_am_val", 32'(am_val), 32'(e.am));
        check("sb_vib_deep", 32'(vib_deep), 32'(e.deep));
        am_at[e.pos] = int'(am_val);
        if (int'(am_val) > am_max) am_max = int'(am_val);
      end
    end
  end

  initial begin
    int asym;
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    dam         = 1'b0;
    dvb         = 1'b0;
`ifdef FM_LFO_TEST_EN
    lfo_test    = 2'b00;
`endif
    for (int i = 0; i < 210; i++) am_at[i] = -1;

    // Reset state, with a tick applied while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_am_val", 32'(am_val), 32'd0);
    check("rst_vib_pos", 32'(vib_pos), 32'd0);
    check("rst_vib_deep", 32'(vib_deep), 32'd0);
    check("rst_lfo_upd", 32'(lfo_upd), 32'd0);
    sample_tick = 1'b1;
    @(posedge clk) #1;
    sample_tick = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("tick_in_reset_timer", 32'(dut.timer_q), 32'd0);

    // First tremolo step lands on the 64th tick.
    dam = 1'b1;
    tick_n(63);
    check("t63_trem_pos", 32'(dut.trem_pos_q), 32'd0);
    check("t63_am_val", 32'(am_val), 32'd0);
    sample_tick = 1'b1;
    model_tick();
    @(posedge clk) #1;
    sample_tick = 1'b0;
    check("t64_trem_pos", 32'(dut.trem_pos_q), 32'd1);
    check("t64_lfo_upd_T1", 32'(lfo_upd), 32'd0);
    @(posedge clk) #1;
    check("t64_lfo_upd_T2", 32'(lfo_upd), 32'd1);
    check("t64_am_val", 32'(am_val), 32'd0);
    @(posedge clk) #1;
    check("t64_lfo_upd_T3", 32'(lfo_upd), 32'd0);

    // Tremolo peak, then depth change takes effect only on the next tick.
    tick_n(6720 - 64);
    check("peak_trem_pos", 32'(dut.trem_pos_q), 32'd105);
    check("peak_am_deep", 32'(am_val), 32'd26);
    dam = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dam_hold", 32'(am_val), 32'd26);
    tick();
    check("peak_am_shallow", 32'(am_val), 32'd6);
    dam = 1'b1;

    // Full tremolo period: wrap, peak and symmetry.
    tick_n(13440 - 6721);
    check("wrap_trem_pos", 32'(dut.trem_pos_q), 32'd0);
    check("wrap_am_val", 32'(am_val), 32'd0);
    check("am_max", 32'(am_max), 32'd26);
    asym = 0;
    for (int p = 1; p < 105; p++) begin
      if (am_at[p] != am_at[210 - p] || am_at[p] < 0) asym++;
    end
    check("am_symmetry", 32'(asym), 32'd0);
    check("run_vib_pos", 32'(vib_pos), 32'd5);

    // dvb changed between ticks is held until the next tick.
    dvb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("dvb_hold", 32'(vib_deep), 32'd0);
    tick();
    check("dvb_loaded", 32'(vib_deep), 32'd1);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk) #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst_am_val", 32'(am_val), 32'd0);
    check("async_rst_vib_pos", 32'(vib_pos), 32'd0);
    check("async_rst_vib_deep", 32'(vib_deep), 32'd0);
    check("async_rst_lfo_upd", 32'(lfo_upd), 32'd0);
    check("async_rst_timer", 32'(dut.timer_q), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    tick();
    check("post_rst_timer", 32'(dut.timer_q), 32'd1);

    // Vibrato stepping and wrap.
    tick_n(1022);
    check("vib_t1023", 32'(vib_pos), 32'd0);
    tick();
    check("vib_t1024", 32'(vib_pos), 32'd1);
    tick_n(7168 - 1024);
    check("vib_t7168", 32'(vib_pos), 32'd7);
    tick_n(1024);
    check("vib_wrap", 32'(vib_pos), 32'd0);

    // Back-to-back ticks straddling a tremolo step (timer 254 and 255).
    do_reset();
    dvb = 1'b0;
    tick_n(254);
    check("b2b_pre_trem", 32'(dut.trem_pos_q), 32'd3);
    sample_tick = 1'b1;
    model_tick();
    @(posedge clk) #1;
    model_tick();
    @(posedge clk) #1;
    sample_tick = 1'b0;
    check("b2b_timer", 32'(dut.timer_q), 32'd256);
    check("b2b_trem", 32'(dut.trem_pos_q), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_am_val", 32'(am_val), 32'd1);

`ifdef FM_LFO_TEST_EN
    // Fast sweep mode and synchronous clear.
    do_reset();
    fast_mode = 1'b1;
    lfo_test  = 2'b10;
    tick_n(105);
    check("fast_am_val", 32'(am_val), 32'd26);
    check("fast_trem", 32'(dut.trem_pos_q), 32'd105);
    check("fast_vib", 32'(vib_pos), 32'd1);
    check("fast_timer", 32'(dut.timer_q), 32'd105);
    lfo_test    = 2'b01;
    sample_tick = 1'b1;
    @(posedge clk) #1;
    sample_tick = 1'b0;
    lfo_test    = 2'b00;
    fast_mode   = 1'b0;
    model_clear();
    check("clr_trem", 32'(dut.trem_pos_q), 32'd0);
    check("clr_timer", 32'(dut.timer_q), 32'd0);
    check("clr_vib", 32'(vib_pos), 32'd0);
    check("clr_am_val", 32'(am_val), 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish before limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
